traffic_intersection_ctrl: RTL and testbench
============================================

Name: traffic_intersection_ctrl

Overview:
Sequencer for a two-road intersection: north-south (NS, main road) and east-west (EW, side road with car sensor) plus a pedestrian crossing.
- Drives both directions' light codes through a fixed phase ring with yellow and all-red clearance intervals.
- Counts phase time with a loadable down-counter advanced by an external 1-cycle tick (e.g. 1 Hz strobe).
- Rests in NS green until a side-road or pedestrian request is pending.
- Sits above the per-lamp display logic; owns all timing and safety sequencing.

Parameters:
TW, 8, width of time inputs and time_left
DEF_NS_GREEN, 8'd30, time_left value loaded by reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  timer advance strobe, one clk wide
ns_green_time  in  TW  NS green duration in ticks (sampled at phase load)
ew_green_time  in  TW  EW green duration in ticks
yellow_time  in  TW  yellow duration in ticks (both roads)
all_red_time  in  TW  clearance duration in ticks
ew_req  in  1  EW car sensor, level or pulse
ped_req  in  1  pedestrian button, pulse
ns_light  out  2  00 green, 01 yellow, 10 red
ew_light  out  2  same encoding
ped_walk  out  1  walk signal for crossing the NS road
time_left  out  TW  remaining ticks in current phase
phase  out  3  current phase code

Behaviour:
- Phases: NS_G=0, NS_Y=1, AR_A=2, EW_G=3, EW_Y=4, AR_B=5; codes 6/7 unreachable and recover to NS_G on next clk.
- Lights are decoded from phase and registered with it:
  - NS_G: ns=00, ew=10.
  - NS_Y: ns=01, ew=10.
  - AR_A/AR_B: both 10.
  - EW_G: ns=10, ew=00.
  - EW_Y: ns=10, ew=01.
- 2'b11 is never driven. ns_light and ew_light are never both non-red in any cycle.
- Reset (async, immediate, also mid-phase): phase=NS_G, ns_light=00, ew_light=10, ped_walk=0, time_left=DEF_NS_GREEN, ew_pend=0, ped_pend=0.
- Timer:
  - On clk with tick=1 and time_left!=0: time_left decrements.
  - With tick=0: time_left holds.
  - A phase loaded with T lasts T+1 ticks. T=0 gives 1 tick.
- Expiry (tick=1 and time_left==0):
  - NS_G: if ew_pend or ped_pend, go to NS_Y and load yellow_time. Otherwise stay in NS_G with time_left held at 0 (rest in green), and leave on the first tick after a request is pending.
  - NS_Y -> AR_A, load all_red_time.
  - AR_A -> EW_G, load ew_green_time. Clear ew_pend. ped_walk = ped_pend, then clear ped_pend.
  - EW_G -> EW_Y, load yellow_time, ped_walk=0.
  - EW_Y -> AR_B, load all_red_time.
  - AR_B -> NS_G, load ns_green_time.
- Time inputs are sampled only on the load edge. Changes mid-phase do not affect the running phase.
- Request latching:
  - ew_req=1 or ped_req=1 sets the respective pend flag in every phase.
  - On the AR_A->EW_G edge, clear wins over a simultaneous set; that request counts as served.
  - Requests arriving during EW_G/EW_Y/AR_B stay pending and cause another EW cycle after the next NS green.
- Latency: outputs change on the same clk edge as the phase change. No combinational path from inputs to outputs.

Decomposition:
- traffic_pkg:
  - light encodings GREEN/YELLOW/RED.
  - phase codes.
  - default-time constants.
- Sub-module phase_timer (TW-bit loadable down-counter):
  - inputs: clk, rst, tick, load, load_val.
  - outputs: count, zero.
- FSM, request latches and light decode stay in traffic_intersection_ctrl.

Test Plan:
Common setup: DEF_NS_GREEN=2, ns_green=2, ew_green=3, yellow=1, all_red=0, tick=1 every clk.
- Reset then hold ew_req=1 one cycle -> after reset release:
  - 2,1,0 in NS_G.
  - edge 3: NS_Y tl=1.
  - edge 5: AR_A tl=0, both red.
  - edge 6: EW_G tl=3, ew=00.
  - edge 10: EW_Y.
  - edge 12: AR_B.
  - edge 13: NS_G tl=2.
- No requests for 50 cycles -> phase stays NS_G, time_left 0, ns=00, ew=10 throughout. Pulse ped_req -> NS_Y on the next tick, and ped_walk=1 exactly during EW_G.
- ew_req asserted on the AR_A->EW_G edge -> ew_pend=0 afterwards; after AR_B, NS_G rests (no second EW cycle). ew_req during EW_G instead -> a second EW cycle follows.
- tick asserted every 4th clk -> each phase lasts 4*(T+1) clks. Change yellow_time 1->5 mid-NS_Y -> current yellow unaffected, next yellow lasts 6 ticks.
- Assert rst during EW_G with tl=2 -> outputs reach reset values before the next clk edge. Release -> normal sequence restarts.
- Throughout all tests, assert every clk that ns_light!=11, ew_light!=11, and that at least one of them is 10.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings and constants for the two-road intersection sequencer.
package traffic_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    localparam logic [2:0] NS_G = 3'd0;
    localparam logic [2:0] NS_Y = 3'd1;
    localparam logic [2:0] AR_A = 3'd2;
    localparam logic [2:0] EW_G = 3'd3;
    localparam logic [2:0] EW_Y = 3'd4;
    localparam logic [2:0] AR_B = 3'd5;

    localparam int DEF_TW             = 8;
    localparam int DEF_NS_GREEN_TICKS = 30;

    typedef struct packed {
        logic [1:0] ns;
        logic [1:0] ew;
    } lights_t;

    // Any code outside the ring decodes to all-red.
    function automatic lights_t decode_lights(input logic [2:0] ph);
        lights_t l;
        l.ns = RED;
        l.ew = RED;
        case (ph)
            NS_G:    l.ns = GREEN;
            NS_Y:    l.ns = YELLOW;
            EW_G:    l.ew = GREEN;
            EW_Y:    l.ew = YELLOW;
            default: ;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_intersection_ctrl_phase_timer.sv
// Loadable down-counter that advances on tick and parks at zero.
module phase_timer #(
    parameter int            TW      = 8,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] count,
    output logic          zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (tick && !zero) begin
            count <= count - TW'(1);
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Phase ring, request latches and registered light decode for the intersection.
//   phase | meaning
//   NS_G  | main road green, rests here until a request is pending
//   NS_Y  | main road yellow
//   AR_A  | all-red clearance before side road
//   EW_G  | side road green, pedestrian walk if requested
//   EW_Y  | side road yellow
//   AR_B  | all-red clearance before main road
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int            TW           = DEF_TW,
    parameter logic [TW-1:0] DEF_NS_GREEN = TW'(DEF_NS_GREEN_TICKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [TW-1:0] ns_green_time,
    input  logic [TW-1:0] ew_green_time,
    input  logic [TW-1:0] yellow_time,
    input  logic [TW-1:0] all_red_time,
    input  logic          ew_req,
    input  logic          ped_req,
    output logic [1:0]    ns_light,
    output logic [1:0]    ew_light,
    output logic          ped_walk,
    output logic [TW-1:0] time_left,
    output logic [2:0]    phase
);

    logic [2:0]    phase_nxt;
    logic          load;
    logic [TW-1:0] load_val;
    logic          serve;
    logic          zero;
    logic          expire;
    logic          ew_pend;
    logic          ped_pend;
    lights_t       lights_nxt;

    phase_timer #(
        .TW      (TW),
        .RST_VAL (DEF_NS_GREEN)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .count    (time_left),
        .zero     (zero)
    );

    assign expire = tick && zero;

    always_comb begin
        phase_nxt = phase;
        load      = 1'b0;
        load_val  = ns_green_time;
        serve     = 1'b0;
        case (phase)
            NS_G: if (expire && (ew_pend || ped_pend)) begin
                phase_nxt = NS_Y;
                load      = 1'b1;
                load_val  = yellow_time;
            end
            NS_Y: if (expire) begin
                phase_nxt = AR_A;
                load      = 1'b1;
                load_val  = all_red_time;
            end
            AR_A: if (expire) begin
                phase_nxt = EW_G;
                load      = 1'b1;
                load_val  = ew_green_time;
                serve     = 1'b1;
            end
            EW_G: if (expire) begin
                phase_nxt = EW_Y;
                load      = 1'b1;
                load_val  = yellow_time;
            end
            EW_Y: if (expire) begin
                phase_nxt = AR_B;
                load      = 1'b1;
                load_val  = all_red_time;
            end
            AR_B: if (expire) begin
                phase_nxt = NS_G;
                load      = 1'b1;
                load_val  = ns_green_time;
            end
            default: begin
                phase_nxt = NS_G;
                load      = 1'b1;
                load_val  = ns_green_time;
            end
        endcase
        lights_nxt = decode_lights(phase_nxt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= NS_G;
            ns_light <= GREEN;
            ew_light <= RED;
            ped_walk <= 1'b0;
            ew_pend  <= 1'b0;
            ped_pend <= 1'b0;
        end else begin
            phase    <= phase_nxt;
            ns_light <= lights_nxt.ns;
            ew_light <= lights_nxt.ew;
            // A request landing on the serve edge is absorbed by this EW cycle.
            ew_pend  <= serve ? 1'b0 : (ew_pend | ew_req);
            ped_pend <= serve ? 1'b0 : (ped_pend | ped_req);
            if (serve) begin
                ped_walk <= ped_pend;
            end else if (phase_nxt != EW_G) begin
                ped_walk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed scoreboard bench for traffic_intersection_ctrl.
module tb_traffic_intersection_ctrl;
    import traffic_pkg::*;

    logic       clk, rst, tick, ew_req, ped_req;
    logic [7:0] ns_green_time, ew_green_time, yellow_time, all_red_time;
    logic [1:0] ns_light, ew_light;
    logic       ped_walk;
    logic [7:0] time_left;
    logic [2:0] phase;

    traffic_intersection_ctrl #(.TW(8), .DEF_NS_GREEN(8'd2)) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .ns_green_time (ns_green_time),
        .ew_green_time (ew_green_time),
        .yellow_time   (yellow_time),
        .all_red_time  (all_red_time),
        .ew_req        (ew_req),
        .ped_req       (ped_req),
        .ns_light      (ns_light),
        .ew_light      (ew_light),
        .ped_walk      (ped_walk),
        .time_left     (time_left),
        .phase         (phase)
    );

    typedef struct packed {
        logic [2:0] ph;
        logic [7:0] tl;
        logic [1:0] ns;
        logic [1:0] ew;
        logic       walk;
    } obs_t;

    obs_t  sb[$];
    string sb_tag[$];
    int    n_total  = 0;
    int    n_pass   = 0;
    int    n_fail   = 0;
    int    tick_div = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_lights(input logic [2:0] ph);
        case (ph)
            3'd0:    return {2'b00, 2'b10};
            3'd1:    return {2'b01, 2'b10};
            3'd3:    return {2'b10, 2'b00};
            3'd4:    return {2'b10, 2'b01};
            default: return {2'b10, 2'b10};
        endcase
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] ph, input int tl, input logic walk);
        obs_t e;
        e.ph = ph;
        e.tl = 8'(tl);
        {e.ns, e.ew} = exp_lights(ph);
        e.walk = walk;
        sb.push_back(e);
        sb_tag.push_back(tag);
    endtask

    task automatic check_head();
        obs_t  e, o;
        string tag;
        e = sb.pop_front();
        tag = sb_tag.pop_front();
        o.ph = phase;
        o.tl = time_left;
        o.ns = ns_light;
        o.ew = ew_light;
        o.walk = ped_walk;
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed ph=%0d tl=%0d ns=%b ew=%b walk=%b, expected ph=%0d tl=%0d ns=%b ew=%b walk=%b",
                   tag, o.ph, o.tl, o.ns, o.ew, o.walk, e.ph, e.tl, e.ns, e.ew, e.walk);
        end
    endtask

    // One timer tick: tick edge (with optional request pulse) plus tick_div-1 idle edges.
    task automatic tick_step(input string tag, input logic [2:0] ph, input int tl,
                             input logic walk, input logic ew_r, input logic ped_r);
        for (int k = 0; k < tick_div; k++) begin
            tick    = (k == 0);
            ew_req  = (k == 0) && ew_r;
            ped_req = (k == 0) && ped_r;
            push_exp(tag, ph, tl, walk);
            @(posedge clk);
            #1;
            check_head();
        end
        tick    = 1'b0;
        ew_req  = 1'b0;
        ped_req = 1'b0;
    endtask

    // Full side-road cycle starting with the edge that leaves NS_G, ending on the NS_G reload.
    task automatic cycle_ew(input string tag, input logic walk, input logic req_at_serve,
                            input logic req_in_ewg, input int new_yellow);
        int yel;
        yel = int'(yellow_time);
        for (int t = yel; t >= 0; t--) begin
            tick_step({tag, "_ns_y"}, NS_Y, t, 1'b0, 1'b0, 1'b0);
            if (t == yel && new_yellow >= 0) yellow_time = 8'(new_yellow);
        end
        for (int t = int'(all_red_time); t >= 0; t--)
            tick_step({tag, "_ar_a"}, AR_A, t, 1'b0, 1'b0, 1'b0);
        for (int t = int'(ew_green_time); t >= 0; t--)
            tick_step({tag, "_ew_g"}, EW_G, t, walk,
                      (t == int'(ew_green_time) && req_at_serve) || (t == 1 && req_in_ewg), 1'b0);
        for (int t = int'(yellow_time); t >= 0; t--)
            tick_step({tag, "_ew_y"}, EW_Y, t, 1'b0, 1'b0, 1'b0);
        for (int t = int'(all_red_time); t >= 0; t--)
            tick_step({tag, "_ar_b"}, AR_B, t, 1'b0, 1'b0, 1'b0);
        tick_step({tag, "_ns_g_reload"}, NS_G, int'(ns_green_time), 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        n_total++;
        assert ((ns_light !== 2'b11) && (ew_light !== 2'b11) &&
                ((ns_light === 2'b10) || (ew_light === 2'b10))) n_pass++;
        else begin
            n_fail++;
            $error("FAIL safety: observed ns=%b ew=%b, expected no 11 and at least one 10", ns_light, ew_light);
        end
    end

    initial begin
        rst = 1'b1; tick = 1'b0; ew_req = 1'b0; ped_req = 1'b0;
        ns_green_time = 8'd2; ew_green_time = 8'd3; yellow_time = 8'd1; all_red_time = 8'd0;
        #2;
        push_exp("reset_state", NS_G, 2, 1'b0);
        check_head();
        tick_step("reset_hold", NS_G, 2, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic ring with an EW request right after reset release.
        tick_step("t1_ns_g", NS_G, 1, 1'b0, 1'b1, 1'b0);
        tick_step("t1_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);
        cycle_ew("t1", 1'b0, 1'b0, 1'b0, -1);
        tick_step("t1_ns_g", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t1_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);

        // Rest in green, then a pedestrian pulse.
        repeat (50) tick_step("t2_rest", NS_G, 0, 1'b0, 1'b0, 1'b0);
        tick_step("t2_ped_pulse", NS_G, 0, 1'b0, 1'b0, 1'b1);
        cycle_ew("t2", 1'b1, 1'b0, 1'b0, -1);
        tick_step("t2_ns_g", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t2_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick_step("t2_rest_after", NS_G, 0, 1'b0, 1'b0, 1'b0);

        // Request on the serve edge is absorbed.
        tick_step("t3a_req", NS_G, 0, 1'b0, 1'b1, 1'b0);
        cycle_ew("t3a", 1'b0, 1'b1, 1'b0, -1);
        tick_step("t3a_ns_g", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t3a_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);
        repeat (6) tick_step("t3a_rest", NS_G, 0, 1'b0, 1'b0, 1'b0);

        // Request during EW green forces a second cycle.
        tick_step("t3b_req", NS_G, 0, 1'b0, 1'b1, 1'b0);
        cycle_ew("t3b", 1'b0, 1'b0, 1'b1, -1);
        tick_step("t3b_ns_g", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t3b_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);
        cycle_ew("t3b_second", 1'b0, 1'b0, 1'b0, -1);
        tick_step("t3b_ns_g2", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t3b_ns_g2", NS_G, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick_step("t3b_rest", NS_G, 0, 1'b0, 1'b0, 1'b0);

        // Slow tick and a yellow_time change during NS yellow.
        tick_div = 4;
        tick_step("t4_req", NS_G, 0, 1'b0, 1'b1, 1'b0);
        cycle_ew("t4", 1'b0, 1'b0, 1'b0, 5);
        tick_step("t4_ns_g", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t4_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);
        tick_div = 1;
        yellow_time = 8'd1;

        // Asynchronous reset in EW green with a request pending.
        tick_step("t5_req", NS_G, 0, 1'b0, 1'b1, 1'b0);
        tick_step("t5_ns_y", NS_Y, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t5_ns_y", NS_Y, 0, 1'b0, 1'b0, 1'b0);
        tick_step("t5_ar_a", AR_A, 0, 1'b0, 1'b0, 1'b0);
        tick_step("t5_ew_g", EW_G, 3, 1'b0, 1'b0, 1'b0);
        tick_step("t5_ew_g", EW_G, 2, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        push_exp("t5_async_reset", NS_G, 2, 1'b0);
        check_head();
        tick_step("t5_reset_hold", NS_G, 2, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick_step("t5_ns_g", NS_G, 1, 1'b0, 1'b0, 1'b0);
        tick_step("t5_ns_g", NS_G, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick_step("t5_rest", NS_G, 0, 1'b0, 1'b0, 1'b0);
        tick_step("t5_restart_req", NS_G, 0, 1'b0, 1'b1, 1'b0);
        cycle_ew("t5_restart", 1'b0, 1'b0, 1'b0, -1);
        tick_step("t5_ns_g_end", NS_G, 1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
